// File: rtl/dma_sched_pkg.sv
// dma_sched_pkg: shared types for the DMA command scheduler.
// Optional feature macro: DMA_SCHED_WRITE_FENCE_EN (see top).
package dma_sched_pkg;

    localparam int MODE_W = 2;
    localparam int ADDR_W = 64;
    localparam int LEN_W  = 32;

    localparam logic [MODE_W-1:0] DMA_MODE_READ  = 2'd1;
    localparam logic [MODE_W-1:0] DMA_MODE_WRITE = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        FENCE,
        DONE
    } state_t;

    typedef struct packed {
        logic [MODE_W-1:0] mode;
        logic [ADDR_W-1:0] ext_addr;
        logic [LEN_W-1:0]  len;
        logic [LEN_W-1:0]  stride;
        logic [LEN_W-1:0]  seg_stride;
        logic [LEN_W-1:0]  seg_count;
    } desc_t;

    function automatic logic mode_ok(input logic [MODE_W-1:0] m);
        return (m == DMA_MODE_READ) || (m == DMA_MODE_WRITE);
    endfunction

endpackage

// File: rtl/dma_cmd_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request at/after ptr.
// Pointer state is owned by the instantiating block.
module rr_arbiter
    import dma_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int RR_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [RR_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [RR_W-1:0]    idx,
    output logic               any
);

    logic [RR_W-1:0] k;

    // scan from ptr upward with wrap, first hit wins
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = RR_W'((int'(ptr) + i) % NUM_REQ);
            if (!any && req[k]) begin
                any      = 1'b1;
                grant[k] = 1'b1;
                idx      = k;
            end
        end
    end

endmodule

// File: rtl/dma_cmd_scheduler.sv
// dma_cmd_scheduler: shares one DMA command port among NUM_REQ requesters.
// Define DMA_SCHED_WRITE_FENCE_EN to hold write completion until writes drain.
module dma_cmd_scheduler
    import dma_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int RR_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*2-1:0]  req_mode,
    input  logic [NUM_REQ*64-1:0] req_ext_addr,
    input  logic [NUM_REQ*32-1:0] req_len,
    input  logic [NUM_REQ*32-1:0] req_stride,
    input  logic [NUM_REQ*32-1:0] req_seg_stride,
    input  logic [NUM_REQ*32-1:0] req_seg_count,
    output logic [NUM_REQ-1:0]    req_done,
    output logic                  req_err,
    output logic                  dma_start,
    output logic [1:0]            dma_mode,
    output logic [63:0]           dma_ext_addr,
    output logic [31:0]           dma_len,
    output logic [31:0]           dma_stride,
    output logic [31:0]           dma_seg_stride,
    output logic [31:0]           dma_seg_count,
    input  logic                  dma_done,
    input  logic                  dma_queue_wr_ready,
    input  logic                  dma_write_idle,
    output logic                  busy,
    output logic [RR_W-1:0]       cur_owner
);

    state_t               state_q, state_d;
    logic [RR_W-1:0]      rr_ptr_q;
    logic [RR_W-1:0]      owner_q;
    desc_t                desc_q;
    desc_t                sel;
    logic                 err_q;
    logic [NUM_REQ-1:0]   grant;
    logic [RR_W-1:0]      grant_idx;
    logic                 grant_any;
    logic                 accept;

`ifndef DMA_SCHED_WRITE_FENCE_EN
    logic unused_write_idle;
    assign unused_write_idle = dma_write_idle;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .RR_W    (RR_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    assign accept = (state_q == IDLE) && grant_any;

    // pick the granted requester's descriptor fields
    always_comb begin
        sel            = '0;
        sel.mode       = req_mode[int'(grant_idx)*2 +: 2];
        sel.ext_addr   = req_ext_addr[int'(grant_idx)*64 +: 64];
        sel.len        = req_len[int'(grant_idx)*32 +: 32];
        sel.stride     = req_stride[int'(grant_idx)*32 +: 32];
        sel.seg_stride = req_seg_stride[int'(grant_idx)*32 +: 32];
        sel.seg_count  = req_seg_count[int'(grant_idx)*32 +: 32];
    end

    // state, owner, latched descriptor and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            desc_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                desc_q  <= sel;
                owner_q <= grant_idx;
                err_q   <= !mode_ok(sel.mode);
            end
            if (state_q == DONE) begin
                rr_ptr_q <= RR_W'((int'(owner_q) + 1) % NUM_REQ);
            end
        end
    end

    // next state and handshake pulses; all pulses held low in reset
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        dma_start = 1'b0;
        req_done  = '0;
        req_err   = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        req_ready = grant;
                        state_d   = ISSUE;
                    end
                end
                ISSUE: begin
                    if (err_q) begin
                        state_d = DONE;
                    end else if (dma_queue_wr_ready) begin
                        dma_start = 1'b1;
                        state_d   = WAIT;
                    end
                end
                WAIT: begin
                    if (dma_done) begin
`ifdef DMA_SCHED_WRITE_FENCE_EN
                        if (desc_q.mode == DMA_MODE_WRITE) begin
                            state_d = FENCE;
                        end else begin
                            state_d = DONE;
                        end
`else
                        state_d = DONE;
`endif
                    end
                end
                FENCE: begin
`ifdef DMA_SCHED_WRITE_FENCE_EN
                    if (dma_write_idle) begin
                        state_d = DONE;
                    end
`else
                    state_d = IDLE;
`endif
                end
                DONE: begin
                    req_done[owner_q] = 1'b1;
                    req_err           = err_q;
                    state_d           = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy           = (state_q != IDLE);
    assign cur_owner      = owner_q;
    assign dma_mode       = desc_q.mode;
    assign dma_ext_addr   = desc_q.ext_addr;
    assign dma_len        = desc_q.len;
    assign dma_stride     = desc_q.stride;
    assign dma_seg_stride = desc_q.seg_stride;
    assign dma_seg_count  = desc_q.seg_count;

endmodule

// File: tb/tb_dma_cmd_scheduler.sv
// tb_dma_cmd_scheduler: directed tests with a transaction-level model.
// Honours DMA_SCHED_WRITE_FENCE_EN the same way as the design.
module tb_dma_cmd_scheduler;

    localparam int N  = 4;
    localparam int RW = 2;

`ifdef DMA_SCHED_WRITE_FENCE_EN
    localparam bit FEN = 1'b1;
`else
    localparam bit FEN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b1;
    logic [N-1:0]    req_valid, req_ready, req_done;
    logic [N*2-1:0]  req_mode;
    logic [N*64-1:0] req_ext_addr;
    logic [N*32-1:0] req_len, req_stride;
    logic [N*32-1:0] req_seg_stride, req_seg_count;
    logic            req_err, dma_start;
    logic [1:0]      dma_mode;
    logic [63:0]     dma_ext_addr;
    logic [31:0]     dma_len, dma_stride;
    logic [31:0]     dma_seg_stride, dma_seg_count;
    logic            dma_done, dma_queue_wr_ready;
    logic            dma_write_idle, busy;
    logic [RW-1:0]   cur_owner;

    logic [1:0]  d_mode [N];
    logic [63:0] d_addr [N];
    logic [31:0] d_len  [N];
    logic [31:0] d_str  [N];
    logic [31:0] d_sstr [N];
    logic [31:0] d_scnt [N];

    always_comb begin
        req_mode       = '0;
        req_ext_addr   = '0;
        req_len        = '0;
        req_stride     = '0;
        req_seg_stride = '0;
        req_seg_count  = '0;
        for (int i = 0; i < N; i++) begin
            req_mode[2*i +: 2]        = d_mode[i];
            req_ext_addr[64*i +: 64]  = d_addr[i];
            req_len[32*i +: 32]       = d_len[i];
            req_stride[32*i +: 32]    = d_str[i];
            req_seg_stride[32*i +: 32] = d_sstr[i];
            req_seg_count[32*i +: 32] = d_scnt[i];
        end
    end

    dma_cmd_scheduler #(.NUM_REQ(N), .RR_W(RW)) dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_mode           (req_mode),
        .req_ext_addr       (req_ext_addr),
        .req_len            (req_len),
        .req_stride         (req_stride),
        .req_seg_stride     (req_seg_stride),
        .req_seg_count      (req_seg_count),
        .req_done           (req_done),
        .req_err            (req_err),
        .dma_start          (dma_start),
        .dma_mode           (dma_mode),
        .dma_ext_addr       (dma_ext_addr),
        .dma_len            (dma_len),
        .dma_stride         (dma_stride),
        .dma_seg_stride     (dma_seg_stride),
        .dma_seg_count      (dma_seg_count),
        .dma_done           (dma_done),
        .dma_queue_wr_ready (dma_queue_wr_ready),
        .dma_write_idle     (dma_write_idle),
        .busy               (busy),
        .cur_owner          (cur_owner)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // observation log
    int cyc = 0;
    int n_acc = 0, n_start = 0, n_done = 0;
    int l_acc, l_start, l_dd, l_done;
    logic [N-1:0] l_rdy, l_dvec;
    logic [63:0]  l_saddr;
    logic         l_err;
    int glog[$];
    int dlog[$];

    // transaction-level model
    int          m_own = -1, m_acc = 0, m_ptr = 0;
    int          m_exp_done = -1;
    bit          m_err, m_wr, m_iss, m_fw;
    logic [1:0]  s_mode;
    logic [63:0] s_addr;
    logic [31:0] s_len, s_str, s_sstr, s_scnt;
    bit          busy_e, done_e, start_e;
    logic [N-1:0] rdy_e, dvec_e;
    int          gsel;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            m_own      = -1;
            m_ptr      = 0;
            m_fw       = 0;
            m_exp_done = -1;
        end else begin
            if (req_ready != 0) begin
                n_acc++;
                l_rdy = req_ready;
                l_acc = cyc;
                glog.push_back(idx_of(req_ready));
            end
            if (dma_start) begin
                n_start++;
                l_start = cyc;
                l_saddr = dma_ext_addr;
            end
            if (dma_done) l_dd = cyc;
            if (req_done != 0) begin
                n_done++;
                l_done = cyc;
                l_dvec = req_done;
                l_err  = req_err;
                dlog.push_back(idx_of(req_done));
            end

            busy_e = (m_own >= 0) && (cyc > m_acc);
            done_e = (m_own >= 0) && (cyc == m_exp_done);
            rdy_e  = '0;
            gsel   = -1;
            if (!busy_e) begin
                for (int k = 0; k < N; k++) begin
                    if (gsel < 0 && req_valid[(m_ptr + k) % N])
                        gsel = (m_ptr + k) % N;
                end
                if (gsel >= 0) rdy_e[gsel] = 1'b1;
            end
            chk("req_ready", req_ready, rdy_e);
            chk("busy", busy, busy_e);
            if (busy_e) chk("cur_owner", cur_owner, m_own);
            start_e = busy_e && !m_err && !m_iss && dma_queue_wr_ready;
            chk("dma_start", dma_start, start_e);
            if (busy_e && !m_err) begin
                chk("dma_addr", dma_ext_addr, s_addr);
                chk("dma_mode_len", {dma_mode, dma_len}, {s_mode, s_len});
                chk("dma_strides", {dma_stride, dma_seg_stride},
                    {s_str, s_sstr});
                chk("dma_seg_count", dma_seg_count, s_scnt);
            end
            dvec_e = '0;
            if (done_e) dvec_e[m_own] = 1'b1;
            chk("req_done", req_done, dvec_e);
            chk("req_err", req_err, done_e && m_err);

            if (m_fw && dma_write_idle) begin
                m_exp_done = cyc + 1;
                m_fw       = 0;
            end
            if (start_e) begin
                m_iss = 1;
            end else if (busy_e && m_iss && !m_fw && m_exp_done < 0
                         && dma_done) begin
                if (FEN && m_wr) m_fw = 1;
                else m_exp_done = cyc + 1;
            end
            if (done_e) begin
                m_ptr = (m_own + 1) % N;
                m_own = -1;
            end
            if (gsel >= 0) begin
                m_own  = gsel;
                m_acc  = cyc;
                s_mode = d_mode[gsel];
                s_addr = d_addr[gsel];
                s_len  = d_len[gsel];
                s_str  = d_str[gsel];
                s_sstr = d_sstr[gsel];
                s_scnt = d_scnt[gsel];
                m_err  = !(s_mode == 2'd1 || s_mode == 2'd2);
                m_wr   = (s_mode == 2'd2);
                m_iss  = 0;
                m_fw   = 0;
                m_exp_done = m_err ? cyc + 2 : -1;
            end
        end
    end

    // requester and adapter behaviour, advanced one cycle per tick
    bit keep = 0;
    int done_delay = 3, idle_delay = 0;
    int dcnt = 0, icnt = 0;

    task automatic tick();
        logic [N-1:0] rr;
        logic st;
        @(posedge clk);
        rr = req_ready;
        st = dma_start;
        #1;
        if (!keep) req_valid = req_valid & ~rr;
        if (rst) begin
            dcnt = 0;
            icnt = 0;
            dma_done = 1'b0;
            dma_write_idle = 1'b1;
        end else begin
            dma_done = 1'b0;
            if (icnt > 0) begin
                icnt--;
                if (icnt == 0) dma_write_idle = 1'b1;
            end
            if (st) dcnt = done_delay;
            if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) begin
                    dma_done = 1'b1;
                    if (idle_delay > 0) begin
                        dma_write_idle = 1'b0;
                        icnt = idle_delay;
                    end
                end
            end
        end
    endtask

    function automatic int cnt_of(input int w);
        if (w == 0) return n_acc;
        if (w == 1) return n_start;
        return n_done;
    endfunction

    task automatic wait_cnt(input int w, input int target,
                            input string nm);
        int n = 0;
        while (cnt_of(w) < target && n < 300) begin
            tick();
            n++;
        end
        chk(nm, 64'(cnt_of(w) >= target), 64'd1);
    endtask

    task automatic set_desc(input int i, input logic [1:0] m,
                            input logic [63:0] a, input logic [31:0] l);
        d_mode[i] = m;
        d_addr[i] = a;
        d_len[i]  = l;
        d_str[i]  = 32'd4 + 32'(i);
        d_sstr[i] = 32'h100 * 32'(i);
        d_scnt[i] = 32'd1 + 32'(i);
    endtask

    task automatic rst_pulse();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    int e2 [5] = '{0, 1, 2, 3, 0};
    int na, ns, nd, g0, d0, rise;

    initial begin
        rst = 1'b1;
        req_valid = '0;
        dma_queue_wr_ready = 1'b1;
        dma_done = 1'b0;
        dma_write_idle = 1'b1;
        for (int i = 0; i < N; i++) set_desc(i, 2'd1, 64'h0, 32'd0);

        // reset state, with requests pending
        req_valid = 4'hF;
        repeat (3) tick();
        #2;
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", dma_start, 0);
        chk("rst_done", {req_done, req_err}, 0);
        chk("rst_addr", dma_ext_addr, 0);
        chk("rst_mode_len", {dma_mode, dma_len}, 0);
        chk("rst_owner", cur_owner, 0);
        req_valid = '0;
        rst = 1'b0;
        tick();

        // single read
        set_desc(0, 2'd1, 64'h1000, 32'd64);
        nd = n_done;
        req_valid = 4'b0001;
        wait_cnt(2, nd + 1, "t1_done");
        chk("t1_rdy", l_rdy, 4'b0001);
        chk("t1_start_lat", l_start - l_acc, 1);
        chk("t1_addr", l_saddr, 64'h1000);
        chk("t1_done_lat", l_done - l_dd, 1);
        chk("t1_dvec", l_dvec, 4'b0001);
        chk("t1_err", l_err, 0);

        // fairness with all requesters held
        rst_pulse();
        for (int i = 0; i < N; i++)
            set_desc(i, 2'd1, 64'h2000 + 64'(i) * 64'h100, 32'd16);
        g0 = glog.size();
        d0 = dlog.size();
        nd = n_done;
        keep = 1;
        req_valid = 4'hF;
        wait_cnt(2, nd + 5, "t2_done");
        keep = 0;
        req_valid = '0;
        repeat (2) tick();
        chk("t2_acc_count", glog.size() - g0, 5);
        for (int k = 0; k < 5; k++) begin
            if (g0 + k < glog.size())
                chk("t2_grant", glog[g0 + k], e2[k]);
            if (d0 + k < dlog.size())
                chk("t2_done_own", dlog[d0 + k], e2[k]);
        end

        // backpressure on the command queue
        dma_queue_wr_ready = 1'b0;
        set_desc(1, 2'd1, 64'h3000, 32'd32);
        na = n_acc;
        ns = n_start;
        nd = n_done;
        req_valid = 4'b0010;
        wait_cnt(0, na + 1, "t3_acc");
        repeat (10) tick();
        chk("t3_held", n_start, ns);
        chk("t3_busy", busy, 1);
        dma_queue_wr_ready = 1'b1;
        rise = cyc + 1;
        wait_cnt(1, ns + 1, "t3_start");
        chk("t3_start_cyc", l_start, rise);
        chk("t3_addr", l_saddr, 64'h3000);
        wait_cnt(2, nd + 1, "t3_done");

        // illegal mode, then pointer advance
        set_desc(2, 2'd0, 64'h4000, 32'd8);
        set_desc(3, 2'd1, 64'h4300, 32'd8);
        set_desc(0, 2'd1, 64'h4400, 32'd8);
        ns = n_start;
        nd = n_done;
        req_valid = 4'b0100;
        wait_cnt(2, nd + 1, "t4_done");
        chk("t4_dvec", l_dvec, 4'b0100);
        chk("t4_err", l_err, 1);
        chk("t4_nostart", n_start, ns);
        chk("t4_lat", l_done - l_acc, 2);
        na = n_acc;
        req_valid = 4'b1001;
        wait_cnt(0, na + 1, "t4_acc");
        chk("t4_next", l_rdy, 4'b1000);
        wait_cnt(2, nd + 3, "t4_done2");
        chk("t4_last", l_dvec, 4'b0001);
        chk("t4_last_err", l_err, 0);

        // write completion, with and without drain delay
        done_delay = 2;
        idle_delay = 20;
        set_desc(1, 2'd2, 64'h5000, 32'd128);
        nd = n_done;
        req_valid = 4'b0010;
        wait_cnt(2, nd + 1, "t5_done");
        chk("t5_fence_lat", l_done - l_dd, FEN ? 21 : 1);
        chk("t5_dvec", l_dvec, 4'b0010);
        repeat (25) tick();
        idle_delay = 0;
        set_desc(0, 2'd2, 64'h5100, 32'd64);
        req_valid = 4'b0001;
        wait_cnt(2, nd + 2, "t5_done2");
        chk("t5_idle_lat", l_done - l_dd, FEN ? 2 : 1);

        // reset while a transfer is in flight
        done_delay = 30;
        set_desc(0, 2'd1, 64'h6100, 32'd16);
        ns = n_start;
        nd = n_done;
        req_valid = 4'b0001;
        wait_cnt(1, ns + 1, "t6_start");
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        chk("t6_busy", busy, 0);
        chk("t6_start", dma_start, 0);
        repeat (40) tick();
        chk("t6_nodone", n_done, nd);
        done_delay = 3;
        set_desc(2, 2'd1, 64'h6000, 32'd16);
        req_valid = 4'b0100;
        wait_cnt(2, nd + 1, "t6_done");
        chk("t6_rdy", l_rdy, 4'b0100);
        chk("t6_dvec", l_dvec, 4'b0100);
        chk("t6_addr", l_saddr, 64'h6000);

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
